// File: rtl/kairo_apb_arb.sv
// Three-requester arbiter onto one VALID/READY APB-style bus: round-robin (or S0-priority)
// grant held until completion, with a BUSY timeout that forces an error completion.
module kairo_apb_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter bit          PRIO_S0        = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        S0_APB_VALID,
  input  logic [3:0]  S0_APB_WSTB,
  input  logic [31:0] S0_APB_ADDR,
  input  logic [31:0] S0_APB_WDATA,
  output logic        S0_APB_READY,
  output logic [31:0] S0_APB_RDATA,
  input  logic        S1_APB_VALID,
  input  logic [3:0]  S1_APB_WSTB,
  input  logic [31:0] S1_APB_ADDR,
  input  logic [31:0] S1_APB_WDATA,
  output logic        S1_APB_READY,
  output logic [31:0] S1_APB_RDATA,
  input  logic        S2_APB_VALID,
  input  logic [3:0]  S2_APB_WSTB,
  input  logic [31:0] S2_APB_ADDR,
  input  logic [31:0] S2_APB_WDATA,
  output logic        S2_APB_READY,
  output logic [31:0] S2_APB_RDATA,
  output logic        M_APB_VALID,
  output logic [3:0]  M_APB_WSTB,
  output logic [31:0] M_APB_ADDR,
  output logic [31:0] M_APB_WDATA,
  input  logic        M_APB_READY,
  input  logic [31:0] M_APB_RDATA,
  output logic        TIMEOUT_ERR,
  output logic [31:0] ERR_ADDR
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [1:0]    gnt, gnt_nxt, last, last_nxt, win;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [31:0]   err_addr, err_addr_nxt;

  logic [2:0]  req;
  logic        busy, sel_valid, tmo, m_valid, done, resp;
  logic [3:0]  sel_wstb;
  logic [31:0] sel_addr, sel_wdata, resp_data;

  assign req  = {S2_APB_VALID, S1_APB_VALID, S0_APB_VALID};
  assign busy = (state == BUSY);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_valid = S0_APB_VALID;
    sel_wstb  = S0_APB_WSTB;
    sel_addr  = S0_APB_ADDR;
    sel_wdata = S0_APB_WDATA;
    case (gnt)
      2'd1: begin
        sel_valid = S1_APB_VALID;
        sel_wstb  = S1_APB_WSTB;
        sel_addr  = S1_APB_ADDR;
        sel_wdata = S1_APB_WDATA;
      end
      2'd2: begin
        sel_valid = S2_APB_VALID;
        sel_wstb  = S2_APB_WSTB;
        sel_addr  = S2_APB_ADDR;
        sel_wdata = S2_APB_WDATA;
      end
      default: begin
      end
    endcase
  end

  // Search starts just after the last completed requester; only meaningful when |req.
  always_comb begin
    win = 2'd0;
    if (PRIO_S0 && req[0]) begin
      win = 2'd0;
    end else if (PRIO_S0) begin
      if (last == 2'd1) win = req[2] ? 2'd2 : 2'd1;
      else              win = req[1] ? 2'd1 : 2'd2;
    end else begin
      case (last)
        2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
        2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
        default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
    end
  end

  // A READY arriving in the timeout cycle takes precedence over the forced error.
  assign tmo       = (TIMEOUT_CYCLES > 0) && busy && sel_valid && !M_APB_READY && (tcnt == T_LAST);
  assign m_valid   = busy && sel_valid && !tmo;
  assign done      = m_valid && M_APB_READY;
  assign resp      = done || tmo;
  assign resp_data = done ? M_APB_RDATA : ERR_RDATA;

  assign M_APB_VALID  = m_valid;
  assign M_APB_WSTB   = busy ? sel_wstb  : 4'd0;
  assign M_APB_ADDR   = busy ? sel_addr  : 32'd0;
  assign M_APB_WDATA  = busy ? sel_wdata : 32'd0;
  assign S0_APB_READY = resp && (gnt == 2'd0);
  assign S1_APB_READY = resp && (gnt == 2'd1);
  assign S2_APB_READY = resp && (gnt == 2'd2);
  assign S0_APB_RDATA = S0_APB_READY ? resp_data : 32'd0;
  assign S1_APB_RDATA = S1_APB_READY ? resp_data : 32'd0;
  assign S2_APB_RDATA = S2_APB_READY ? resp_data : 32'd0;
  assign TIMEOUT_ERR  = tmo;
  assign ERR_ADDR     = err_addr;

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_nxt     = last;
    tcnt_nxt     = tcnt;
    err_addr_nxt = err_addr;
    case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (|req) begin
          gnt_nxt   = win;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!sel_valid) begin
          state_nxt = IDLE;
          tcnt_nxt  = '0;
        end else if (resp) begin
          last_nxt  = gnt;
          state_nxt = IDLE;
          tcnt_nxt  = '0;
          if (tmo) err_addr_nxt = sel_addr;
        end else if (tcnt != '1) begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      gnt      <= 2'd0;
      last     <= 2'd2;
      tcnt     <= '0;
      err_addr <= 32'd0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last     <= last_nxt;
      tcnt     <= tcnt_nxt;
      err_addr <= err_addr_nxt;
    end
  end

endmodule

// File: tb/tb_kairo_apb_arb.sv
// Bench for kairo_apb_arb: round-robin and S0-priority instances share stimulus; a
// transaction-level model is compared every cycle, plus hand-computed spot checks.
module tb_kairo_apb_arb;

  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]  sv;
  logic [3:0]  sw [3];
  logic [31:0] sa [3];
  logic [31:0] sd [3];
  logic        m_ready;
  logic [31:0] m_rdata;

  logic        m_valid [2];
  logic [3:0]  m_wstb  [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        s_rdy   [2][3];
  logic [31:0] s_rdata [2][3];
  logic        terr    [2];
  logic [31:0] err_addr[2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    kairo_apb_arb #(.TIMEOUT_CYCLES(8), .ERR_RDATA(ERR), .PRIO_S0(k == 1)) u_dut (
      .CLK(clk), .RST_N(rst_n),
      .S0_APB_VALID(sv[0]), .S0_APB_WSTB(sw[0]), .S0_APB_ADDR(sa[0]), .S0_APB_WDATA(sd[0]),
      .S0_APB_READY(s_rdy[k][0]), .S0_APB_RDATA(s_rdata[k][0]),
      .S1_APB_VALID(sv[1]), .S1_APB_WSTB(sw[1]), .S1_APB_ADDR(sa[1]), .S1_APB_WDATA(sd[1]),
      .S1_APB_READY(s_rdy[k][1]), .S1_APB_RDATA(s_rdata[k][1]),
      .S2_APB_VALID(sv[2]), .S2_APB_WSTB(sw[2]), .S2_APB_ADDR(sa[2]), .S2_APB_WDATA(sd[2]),
      .S2_APB_READY(s_rdy[k][2]), .S2_APB_RDATA(s_rdata[k][2]),
      .M_APB_VALID(m_valid[k]), .M_APB_WSTB(m_wstb[k]), .M_APB_ADDR(m_addr[k]),
      .M_APB_WDATA(m_wdata[k]), .M_APB_READY(m_ready), .M_APB_RDATA(m_rdata),
      .TIMEOUT_ERR(terr[k]), .ERR_ADDR(err_addr[k])
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] rdy_vec(input int k);
    return {s_rdy[k][2], s_rdy[k][1], s_rdy[k][0]};
  endfunction

  // Model: who owns the bus (-1 = nobody), who finished last, how long the owner has waited.
  int          owner  [2];
  int          prev   [2];
  int          waited [2];
  logic [31:0] err_m  [2];
  bit          model_ok = 1'b0;

  function automatic int pick(input bit prio, input logic [2:0] v, input int p);
    if (prio && v[0]) return 0;
    for (int i = 1; i <= 3; i++) begin
      int c = (p + i) % 3;
      if (prio && c == 0) continue;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  logic        e_mv, e_to;
  logic [3:0]  e_w;
  logic [31:0] e_a, e_d;
  logic        e_rdy [3];
  logic [31:0] e_rd  [3];
  int          o;

  // Inputs change only just after posedge, so at negedge they hold for the coming edge too.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (model_ok) begin
        e_mv = 0; e_to = 0; e_w = 0; e_a = 0; e_d = 0;
        for (int i = 0; i < 3; i++) begin e_rdy[i] = 0; e_rd[i] = 0; end
        if (owner[k] >= 0) begin
          o = owner[k];
          e_w = sw[o]; e_a = sa[o]; e_d = sd[o];
          if (sv[o]) begin
            if (m_ready) begin
              e_mv = 1; e_rdy[o] = 1; e_rd[o] = m_rdata;
            end else if (waited[k] == 7) begin
              e_rdy[o] = 1; e_rd[o] = ERR; e_to = 1;
            end else begin
              e_mv = 1;
            end
          end
        end
        check($sformatf("d%0d m_valid", k), m_valid[k], e_mv);
        check($sformatf("d%0d m_wstb", k), m_wstb[k], e_w);
        check($sformatf("d%0d m_addr", k), m_addr[k], e_a);
        check($sformatf("d%0d m_wdata", k), m_wdata[k], e_d);
        check($sformatf("d%0d timeout_err", k), terr[k], e_to);
        check($sformatf("d%0d err_addr", k), err_addr[k], err_m[k]);
        for (int i = 0; i < 3; i++) begin
          check($sformatf("d%0d s%0d_ready", k, i), s_rdy[k][i], e_rdy[i]);
          check($sformatf("d%0d s%0d_rdata", k, i), s_rdata[k][i], e_rd[i]);
        end
      end
      if (!rst_n) begin
        owner[k] = -1; prev[k] = 2; waited[k] = 0; err_m[k] = 0;
      end else if (owner[k] < 0) begin
        owner[k]  = pick(k == 1, sv, prev[k]);
        waited[k] = 0;
      end else begin
        o = owner[k];
        if (!sv[o]) begin
          owner[k] = -1;
        end else if (m_ready || waited[k] == 7) begin
          if (!m_ready) err_m[k] = sa[o];
          prev[k]  = o;
          owner[k] = -1;
        end else begin
          waited[k]++;
        end
        if (owner[k] < 0) waited[k] = 0;
      end
    end
    if (!rst_n) model_ok = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] seq [2][8];
  logic [2:0] exp_seq [2][8];

  initial begin
    rst_n = 0; sv = 0; m_ready = 0; m_rdata = 0;
    for (int i = 0; i < 3; i++) begin sw[i] = 0; sa[i] = 0; sd[i] = 0; end
    exp_seq[0] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    exp_seq[1] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001};
    tick(); tick();
    #1;
    check("reset m_valid", m_valid[0], 1'b0);
    check("reset err_addr", err_addr[0], 32'h0);
    rst_n = 1;

    // Single read, READY on the 2nd VALID cycle.
    sv = 3'b001; sa[0] = 32'h0000_0100;
    #1 check("read arb latency", m_valid[0], 1'b0);
    tick(); #1;
    check("read m_valid c1", m_valid[0], 1'b1);
    check("read m_addr c1", m_addr[0], 32'h0000_0100);
    tick();
    m_ready = 1; m_rdata = 32'h1234_5678;
    #1;
    check("read s0 ready", rdy_vec(0), 3'b001);
    check("read s0 rdata", s_rdata[0][0], 32'h1234_5678);
    tick();
    sv = 0; m_ready = 0; m_rdata = 0;
    #1 check("read idle after", m_valid[0], 1'b0);

    // Contention from reset, zero-wait target.
    rst_n = 0; tick(); rst_n = 1;
    sa[0] = 32'h0000_1000; sa[1] = 32'h0000_2000; sa[2] = 32'h0000_3000;
    sv = 3'b111; m_ready = 1; m_rdata = 32'h55AA_0000;
    for (int t = 0; t < 8; t++) begin
      #1;
      seq[0][t] = rdy_vec(0);
      seq[1][t] = rdy_vec(1);
      tick();
    end
    sv = 0; m_ready = 0; m_rdata = 0;
    for (int k = 0; k < 2; k++)
      for (int t = 0; t < 8; t++)
        check($sformatf("contention d%0d t%0d", k, t), seq[k][t], exp_seq[k][t]);

    // Write passthrough on S2.
    sv = 3'b100; sw[2] = 4'b0011; sa[2] = 32'h8001_0004; sd[2] = 32'hCAFE_F00D;
    tick(); #1;
    check("write m_wstb", m_wstb[0], 4'b0011);
    check("write m_addr", m_addr[1], 32'h8001_0004);
    check("write m_wdata", m_wdata[0], 32'hCAFE_F00D);
    check("write s2 rdata busy", s_rdata[0][2], 32'h0);
    m_ready = 1;
    #1;
    check("write s2 ready", rdy_vec(0), 3'b100);
    check("write s2 rdata done", s_rdata[0][2], 32'h0);
    tick();
    sv = 0; m_ready = 0; sw[2] = 0;

    // Timeout on S1 with a silent target.
    sv = 3'b010; sa[1] = 32'h4000_0010;
    tick();
    for (int c = 1; c < 8; c++) tick();
    #1;
    check("tmo s1 ready", rdy_vec(0), 3'b010);
    check("tmo s1 rdata", s_rdata[0][1], ERR);
    check("tmo pulse", terr[0], 1'b1);
    check("tmo m_valid", m_valid[1], 1'b0);
    tick();
    sv = 0;
    #1;
    check("tmo err_addr", err_addr[0], 32'h4000_0010);
    check("tmo pulse gone", terr[0], 1'b0);

    // READY in the 8th BUSY cycle wins over the timeout.
    sv = 3'b010; sa[1] = 32'h4000_0020;
    tick();
    for (int c = 1; c < 8; c++) tick();
    m_ready = 1; m_rdata = 32'h0BAD_CAFE;
    #1;
    check("late ready s1", rdy_vec(0), 3'b010);
    check("late ready rdata", s_rdata[0][1], 32'h0BAD_CAFE);
    check("late ready no err", terr[0], 1'b0);
    tick();
    sv = 0; m_ready = 0; m_rdata = 0;
    #1 check("late ready err_addr kept", err_addr[0], 32'h4000_0010);

    // Reset in the middle of an S2 transfer; S0 first after release.
    sv = 3'b100;
    tick(); #1;
    check("mid-rst busy", m_valid[0], 1'b1);
    rst_n = 0; sv = 3'b101; sa[0] = 32'h0000_0100;
    tick(); #1;
    check("mid-rst m_valid", m_valid[0], 1'b0);
    check("mid-rst ready", rdy_vec(0), 3'b000);
    check("mid-rst m_addr", m_addr[0], 32'h0);
    check("mid-rst err_addr", err_addr[0], 32'h0);
    rst_n = 1;
    tick(); #1;
    check("post-rst s0 first", m_addr[0], 32'h0000_0100);
    m_ready = 1; m_rdata = 32'h0000_0001;
    tick();
    sv = 0; m_ready = 0; m_rdata = 0;

    // Abort: S0 drops VALID in its 2nd BUSY cycle.
    rst_n = 0; tick(); rst_n = 1;
    sv = 3'b001;
    tick(); #1;
    check("abort c1 valid", m_valid[0], 1'b1);
    tick();
    sv = 3'b000;
    #1;
    check("abort c2 valid", m_valid[0], 1'b0);
    check("abort no ready", rdy_vec(0), 3'b000);
    tick();
    sv = 3'b011; sa[1] = 32'h0000_2000;
    #1 check("abort idle", m_valid[0], 1'b0);
    tick(); #1;
    check("abort s0 still first", m_addr[0], 32'h0000_0100);
    m_ready = 1;
    tick();
    sv = 0; m_ready = 0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
